// File: rtl/geogenius_pkg.sv
// Shared types and helpers for the geogenius game and its automatic player.
// Pure declarations: no logic, no latency, no flow control.
package geogenius_pkg;

    localparam int LED_W = 8;

    typedef enum logic [3:0] {
        E_INICIAL   = 4'd0,
        E_INICIA    = 4'd1,
        E_OBSERVA   = 4'd2,
        E_ESPERA    = 4'd3,
        E_PRESSIONA = 4'd4,
        E_IGNORA    = 4'd5,
        E_FIM       = 4'd6
    } estado_t;

    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jogador_automatico_seq_buffer.sv
// Sequence register file: append-only writes, clear, combinational read at index.
// Write lands 1 cycle later; writes while full are silently dropped (caller flags it).
module seq_buffer
    import geogenius_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [LED_W-1:0] wr_dat,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [LED_W-1:0] rd_dat,
    output logic [IDX_W:0]   count,
    output logic             full
);

    logic [LED_W-1:0] mem [DEPTH];

    assign full   = (count == (IDX_W+1)'(DEPTH));
    assign rd_dat = mem[rd_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            count <= '0;
        end else if (wr_en && !full) begin
            mem[count[IDX_W-1:0]] <= wr_dat;
            count                 <= count + (IDX_W+1)'(1);
        end
    end

endmodule

// File: rtl/jogador_automatico.sv
// Autoplayer: records country LEDs shown by geogenius, then replays them on botoes.
// All outputs registered (1 cycle after inputs); no backpressure, the game paces itself.
module jogador_automatico
    import geogenius_pkg::*;
#(
    parameter int JOGAR_CYC   = 5,
    parameter int QUIET_CYC   = 100,
    parameter int GAP_CYC     = 10,
    parameter int PRESS_CYC   = 10,
    parameter int IGNORE_CYC  = 2100,
    parameter int MAX_JOGADAS = 16,
    localparam int NUM_W      = $clog2(MAX_JOGADAS) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             habilita,
    input  logic [LED_W-1:0] leds,
    input  logic             ganhou,
    input  logic             perdeu,
    output logic             jogar,
    output logic [LED_W-1:0] botoes,
    output logic             fim,
    output logic             venceu,
    output logic             overflow,
    output logic [NUM_W-1:0] num_jogadas,
    output logic [3:0]       db_estado
);

    localparam int MAX_CYC = max_int(max_int(JOGAR_CYC, QUIET_CYC),
                                     max_int(max_int(GAP_CYC, PRESS_CYC), IGNORE_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    estado_t          estado;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] quiet;
    logic [NUM_W-1:0] idx;
    logic [LED_W-1:0] leds_prev;
    logic [LED_W-1:0] rd_dat;
    logic             full;
    logic             evento_fim;
    logic             ativo;
    logic             captura;
    logic             buf_clr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign evento_fim = (ganhou || perdeu) && (estado != E_INICIAL) && (estado != E_FIM);
    assign ativo      = habilita && !evento_fim;
    // Only a fresh one-hot value counts; leds_prev is zeroed outside OBSERVA.
    assign captura    = ativo && (estado == E_OBSERVA) && is_onehot(leds) && (leds != leds_prev);
    assign buf_clr    = ativo && (((estado == E_INICIA) && (cnt == CNT_W'(JOGAR_CYC - 1))) ||
                                  ((estado == E_IGNORA) && (cnt == CNT_W'(IGNORE_CYC - 1))));
    assign db_estado  = estado;

    seq_buffer #(.DEPTH(MAX_JOGADAS)) u_seq_buffer (
        .clock  (clock),
        .reset  (reset),
        .clr    (buf_clr),
        .wr_en  (captura),
        .wr_dat (leds),
        .rd_idx (idx[NUM_W-2:0]),
        .rd_dat (rd_dat),
        .count  (num_jogadas),
        .full   (full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= E_INICIAL;
            cnt       <= '0;
            quiet     <= '0;
            idx       <= '0;
            leds_prev <= '0;
            jogar     <= 1'b0;
            botoes    <= '0;
            fim       <= 1'b0;
            venceu    <= 1'b0;
            overflow  <= 1'b0;
        end else if (!habilita) begin
            estado    <= E_INICIAL;
            cnt       <= '0;
            quiet     <= '0;
            idx       <= '0;
            leds_prev <= '0;
            jogar     <= 1'b0;
            botoes    <= '0;
            fim       <= 1'b0;
            venceu    <= 1'b0;
            overflow  <= 1'b0;
        end else if (evento_fim) begin
            estado <= E_FIM;
            jogar  <= 1'b0;
            botoes <= '0;
            fim    <= 1'b1;
            venceu <= ganhou;
        end else begin
            leds_prev <= '0;
            if (captura && full) begin
                overflow <= 1'b1;
            end
            case (estado)
                E_INICIAL: begin
                    estado <= E_INICIA;
                    jogar  <= 1'b1;
                    cnt    <= '0;
                end
                E_INICIA: begin
                    if (cnt == CNT_W'(JOGAR_CYC - 1)) begin
                        estado <= E_OBSERVA;
                        jogar  <= 1'b0;
                        cnt    <= '0;
                        quiet  <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                E_OBSERVA: begin
                    leds_prev <= leds;
                    if (leds != '0) begin
                        quiet <= '0;
                    end else if (num_jogadas != '0) begin
                        // This sample is the QUIET_CYC-th dark cycle in a row.
                        if (quiet == CNT_W'(QUIET_CYC - 1)) begin
                            estado <= E_ESPERA;
                            idx    <= '0;
                            cnt    <= '0;
                            quiet  <= '0;
                        end else begin
                            quiet <= sat_inc(quiet);
                        end
                    end
                end
                E_ESPERA: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        estado <= E_PRESSIONA;
                        botoes <= rd_dat;
                        cnt    <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                E_PRESSIONA: begin
                    if (cnt == CNT_W'(PRESS_CYC - 1)) begin
                        botoes <= '0;
                        cnt    <= '0;
                        idx    <= idx + NUM_W'(1);
                        estado <= ((idx + NUM_W'(1)) == num_jogadas) ? E_IGNORA : E_ESPERA;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                E_IGNORA: begin
                    if (cnt == CNT_W'(IGNORE_CYC - 1)) begin
                        estado <= E_OBSERVA;
                        cnt    <= '0;
                        quiet  <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                E_FIM: begin
                    fim <= 1'b1;
                end
                default: begin
                    estado <= E_INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: table-driven start/capture vectors, randomized
// capture rounds against a sequence model, and hand sequences for end/reset cases.
module tb_jogador_automatico;

    localparam int J   = 5;
    localparam int Q   = 20;
    localparam int G   = 10;
    localparam int P   = 10;
    localparam int IGN = 30;
    localparam int MAXJ = 16;
    localparam int PER = G + P;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilita = 1'b0;
    logic [7:0] leds = 8'h00;
    logic       ganhou = 1'b0;
    logic       perdeu = 1'b0;
    logic       jogar;
    logic [7:0] botoes;
    logic       fim;
    logic       venceu;
    logic       overflow;
    logic [4:0] num_jogadas;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_nz = 0;
    bit ovf_m = 1'b0;

    always #5 clock = ~clock;

    jogador_automatico #(
        .JOGAR_CYC(J), .QUIET_CYC(Q), .GAP_CYC(G), .PRESS_CYC(P),
        .IGNORE_CYC(IGN), .MAX_JOGADAS(MAXJ)
    ) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .leds(leds),
        .ganhou(ganhou), .perdeu(perdeu), .jogar(jogar), .botoes(botoes),
        .fim(fim), .venceu(venceu), .overflow(overflow),
        .num_jogadas(num_jogadas), .db_estado(db_estado)
    );

    typedef struct {
        logic       hab;
        logic [7:0] leds;
        logic       exp_jogar;
        logic [3:0] exp_estado;
        logic [4:0] exp_num;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic wait_estado(input int target, input int budget);
        int n = 0;
        while (db_estado != 4'(target) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_estado", db_estado, target);
    endtask

    // Expected timeline after the last lit sample: Q dark samples, then
    // (gap, press) pairs per recorded entry, then IGN cycles of feedback blanking.
    task automatic check_replay(input logic [7:0] q[$], input bit ff);
        int n;
        int r;
        int es;
        int eb;
        bit first;
        bit done;
        n = q.size();
        first = 1'b1;
        done = 1'b0;
        while (!done) begin
            tick();
            r = cyc - last_nz - Q - 1;
            eb = 0;
            if (r < 0) es = 2;
            else if (r < PER * n) begin
                es = (r % PER < G) ? 3 : 4;
                eb = (r % PER < G) ? 0 : int'(q[r / PER]);
            end else if (r < PER * n + IGN) es = 5;
            else es = 2;
            chk("replay_estado", db_estado, es);
            chk("replay_botoes", botoes, eb);
            if (first) begin
                chk("captured_count", num_jogadas, n);
                chk("overflow_flag", overflow, ovf_m);
                first = 1'b0;
            end
            if (r == PER * n + IGN) begin
                chk("count_cleared", num_jogadas, 0);
                done = 1'b1;
            end
            leds = (ff && r >= PER * n && r < PER * n + IGN) ? 8'hFF : 8'h00;
        end
    endtask

    task automatic run_round(input logic [7:0] samp[$], input bit ff);
        logic [7:0] q[$];
        logic [7:0] prev;
        foreach (samp[i]) begin
            tick();
            leds = samp[i];
            if (samp[i] != 8'h00) last_nz = cyc;
        end
        prev = 8'h00;
        foreach (samp[i]) begin
            if ($countones(samp[i]) == 1 && samp[i] != prev) begin
                if (q.size() < MAXJ) q.push_back(samp[i]);
                else ovf_m = 1'b1;
            end
            prev = samp[i];
        end
        check_replay(q, ff);
    endtask

    initial begin
        vec_t       vt[$];
        logic [7:0] s[$];
        logic [7:0] eq[$];
        int         nc;
        logic [7:0] v;

        vt.push_back('{1'b0, 8'h00, 1'b0, 4'd0, 5'd0});
        for (int i = 0; i < J; i++) vt.push_back('{1'b1, 8'h00, 1'b1, 4'd1, 5'd0});
        vt.push_back('{1'b1, 8'h00, 1'b0, 4'd2, 5'd0});
        vt.push_back('{1'b1, 8'h01, 1'b0, 4'd2, 5'd1});
        vt.push_back('{1'b1, 8'h00, 1'b0, 4'd2, 5'd1});
        vt.push_back('{1'b1, 8'h08, 1'b0, 4'd2, 5'd2});
        vt.push_back('{1'b1, 8'h08, 1'b0, 4'd2, 5'd2});
        vt.push_back('{1'b1, 8'h00, 1'b0, 4'd2, 5'd2});
        vt.push_back('{1'b1, 8'h08, 1'b0, 4'd2, 5'd3});
        vt.push_back('{1'b1, 8'hFF, 1'b0, 4'd2, 5'd3});
        vt.push_back('{1'b1, 8'h00, 1'b0, 4'd2, 5'd3});

        tick();
        tick();
        chk("rst_estado", db_estado, 0);
        chk("rst_jogar", jogar, 0);
        chk("rst_botoes", botoes, 0);
        chk("rst_fim", fim, 0);
        chk("rst_venceu", venceu, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_num", num_jogadas, 0);
        reset = 1'b1;

        foreach (vt[i]) begin
            habilita = vt[i].hab;
            leds = vt[i].leds;
            if (vt[i].leds != 8'h00) last_nz = cyc;
            tick();
            chk("vec_jogar", jogar, vt[i].exp_jogar);
            chk("vec_estado", db_estado, vt[i].exp_estado);
            chk("vec_num", num_jogadas, vt[i].exp_num);
            chk("vec_botoes", botoes, 0);
        end
        eq = '{8'h01, 8'h08, 8'h08};
        check_replay(eq, 1'b1);

        for (int rd = 0; rd < 12; rd++) begin
            s.delete();
            nc = $urandom_range(1, 20);
            for (int j = 0; j < nc; j++) begin
                v = 8'(1 << $urandom_range(0, 7));
                repeat ($urandom_range(1, 3)) s.push_back(v);
                case ($urandom_range(0, 4))
                    0: ;
                    1: s.push_back(8'h00);
                    2: begin s.push_back(8'h00); s.push_back(8'h00); end
                    3: s.push_back(8'hFF);
                    default: s.push_back(8'h05);
                endcase
            end
            run_round(s, rd[0]);
        end

        s.delete();
        for (int i = 0; i < 17; i++) begin
            s.push_back(8'(1 << (i % 8)));
            s.push_back(8'h00);
        end
        run_round(s, 1'b0);
        chk("overflow_after_17", overflow, 1);

        tick();
        leds = 8'h02;
        tick();
        leds = 8'h00;
        wait_estado(3, 100);
        perdeu = 1'b1;
        tick();
        chk("lost_estado", db_estado, 6);
        chk("lost_fim", fim, 1);
        chk("lost_venceu", venceu, 0);
        chk("lost_botoes", botoes, 0);
        perdeu = 1'b0;
        repeat (3) tick();
        chk("fim_sticky", fim, 1);
        chk("fim_state_held", db_estado, 6);
        habilita = 1'b0;
        ovf_m = 1'b0;
        tick();
        chk("dis_estado", db_estado, 0);
        chk("dis_fim", fim, 0);
        chk("dis_overflow", overflow, 0);

        habilita = 1'b1;
        wait_estado(2, 20);
        ganhou = 1'b1;
        perdeu = 1'b1;
        tick();
        chk("both_estado", db_estado, 6);
        chk("both_venceu", venceu, 1);
        chk("both_fim", fim, 1);
        ganhou = 1'b0;
        perdeu = 1'b0;
        habilita = 1'b0;
        tick();
        chk("both_clear_venceu", venceu, 0);

        habilita = 1'b1;
        wait_estado(2, 20);
        tick();
        leds = 8'h04;
        tick();
        leds = 8'h00;
        for (int n = 0; n < 100 && botoes != 8'h04; n++) tick();
        chk("press_04", botoes, 8'h04);
        repeat (3) tick();
        #1 reset = 1'b0;
        #1;
        chk("async_botoes", botoes, 0);
        chk("async_estado", db_estado, 0);
        chk("async_num", num_jogadas, 0);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
